// File: rtl/lsu_byte_master.sv
// Byte-beat load/store initiator: decodes RV32I funct3, runs little-endian byte beats
// over a req/ack bus and returns one extended response. Optional macro: MISALIGN_TRAP_EN.
module lsu_byte_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               store_q, store_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [1:0]         beat_q, beat_d;
    logic [1:0]         last_q, last_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic               req_ready_d;
    logic               mem_req_d;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [7:0]         mem_wdata_d;
    logic               resp_valid_d;
    logic [31:0]        resp_data_d;
    logic               resp_err_d;

    logic               illegal_c;
    logic               misalign_c;
    logic               tmo_hit_c;
    logic [31:0]        word_c;
    logic [1:0]         beat_nx_c;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  load_ext = {{24{w[7]}}, w[7:0]};
            3'b001:  load_ext = {{16{w[15]}}, w[15:0]};
            3'b100:  load_ext = {24'd0, w[7:0]};
            3'b101:  load_ext = {16'd0, w[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [1:0] last_beat(input logic [1:0] sz);
        case (sz)
            2'b00:   last_beat = 2'd0;
            2'b01:   last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    endfunction

    // Request decode and per-beat helpers
    always_comb begin
        illegal_c = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef MISALIGN_TRAP_EN
        misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
        tmo_hit_c = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
        word_c = rbuf_q;
        word_c[{beat_q, 3'b000} +: 8] = mem_rdata;
        beat_nx_c = beat_q + 2'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        beat_d       = beat_q;
        last_d       = last_q;
        tmo_d        = tmo_q;
        req_ready_d  = req_ready;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data;
        resp_err_d   = resp_err;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    store_d     = req_store;
                    f3_d        = req_funct3;
                    wdata_d     = req_wdata;
                    rbuf_d      = '0;
                    beat_d      = 2'd0;
                    last_d      = last_beat(req_funct3[1:0]);
                    tmo_d       = '0;
                    req_ready_d = 1'b0;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata[7:0];
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (illegal_c || misalign_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_ACCESS;
                        mem_req_d = 1'b1;
                        mem_we_d  = req_store;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    tmo_d = '0;
                    if (!store_q) begin
                        rbuf_d = word_c;
                    end
                    if (beat_q == last_q) begin
                        state_d      = ST_RESP;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_data_d  = store_q ? 32'd0 : load_ext(f3_q, word_c);
                    end else begin
                        beat_d      = beat_nx_c;
                        mem_addr_d  = mem_addr + ADDR_W'(1);
                        mem_wdata_d = wdata_q[{beat_nx_c, 3'b000} +: 8];
                    end
                end else if (tmo_hit_c) begin
                    // Abort the access; bytes already written stay written
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                resp_data_d = '0;
                resp_err_d  = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            store_q    <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            beat_q     <= '0;
            last_q     <= '0;
            tmo_q      <= '0;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            req_ready  <= req_ready_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Self-checking bench for lsu_byte_master against a byte-array reference memory and
// funct3 decode model. Follows MISALIGN_TRAP_EN if defined.
module tb_lsu_byte_master;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TMO    = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;

    lsu_byte_master #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [7:0]  pl_data;
    int          ack_mode;
    int          tick = 0;
    int          miss = 0;
    int          mreq_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] beat_addr_q[$];
    logic        beat_we_q[$];
    logic [7:0]  beat_data_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side responder: ack pattern and read data change on the falling edge
    always @(negedge clk) begin
        tick = tick + 1;
        mem_rdata = mem[mem_addr[9:0]];
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = ((tick % 3) == 0);
            2: mem_ack = 1'b0;
            default: begin
                mem_ack = (miss >= 2) || ($urandom_range(0, 2) != 0);
                miss = mem_ack ? 0 : miss + 1;
            end
        endcase
    end

    // Memory array, completed-beat log and activity counters
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_req === 1'b1) mreq_cnt <= mreq_cnt + 1;
        if (resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            beat_addr_q.push_back(mem_addr);
            beat_we_q.push_back(mem_we);
            beat_data_q.push_back(mem_wdata);
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pl_byte(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
    endtask

    task automatic pl_done();
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit lat_chk, input bit exp_tmo,
                           output logic [31:0] obs_data, output logic obs_err);
        bit legal, mis, err_e;
        int n, nb_try, nb_done, cyc, q0, mr0, k, lat_e;
        logic [31:0] exp_d, mask, a;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = TRAP && (((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00)));
        nb_try = (!legal || mis) ? 0 : n;
        err_e = !legal || mis || exp_tmo;
        nb_done = err_e ? 0 : n;
        exp_d = 32'd0;
        if (!st && !err_e) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                exp_d = exp_d | (32'(ref_mem[a[9:0]]) << (8 * i));
            end
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            if (!f3[2] && exp_d[8 * n - 1]) exp_d = exp_d | ~mask;
        end
        q0 = beat_addr_q.size();
        mr0 = mreq_cnt;

        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        check("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        check("resp_seen", 32'(resp_valid), 32'd1);
        obs_data = resp_data;
        obs_err = resp_err;
        lat_e = exp_tmo ? int'(TMO) + 1 : nb_try + 1;
        if (lat_chk) check("latency", 32'(cyc), 32'(lat_e));
        check("resp_err", 32'(resp_err), 32'(err_e));
        check("resp_data", resp_data, exp_d);
        check("ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("ready_after_resp", 32'(req_ready), 32'd1);
        check("beat_count", 32'(beat_addr_q.size() - q0), 32'(nb_done));
        if (nb_try == 0) check("no_mem_req", 32'(mreq_cnt - mr0), 32'd0);
        if (exp_tmo) check("tmo_req_cycles", 32'(mreq_cnt - mr0), 32'(TMO));
        for (int i = 0; i < nb_done && (q0 + i) < beat_addr_q.size(); i++) begin
            a = addr + 32'(i);
            check("beat_addr", beat_addr_q[q0 + i], a);
            check("beat_we", 32'(beat_we_q[q0 + i]), 32'(st));
            if (st) check("beat_wdata", 32'(beat_data_q[q0 + i]), 32'(wd[8 * i +: 8]));
        end
        if (st && !err_e) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                ref_mem[a[9:0]] = wd[8 * i +: 8];
                check("mem_byte", 32'(mem[a[9:0]]), 32'(ref_mem[a[9:0]]));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          q0, rp0, k;
        logic [2:0]  ill_f3 [6];
        logic        ill_st [6];

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; ack_mode = 0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;

        for (int i = 0; i < 1024; i++) pl_byte(10'(i), 8'($urandom));
        pl_byte(10'h100, 8'h80);
        pl_byte(10'h101, 8'h7F);
        pl_byte(10'h102, 8'h12);
        pl_byte(10'h103, 8'hFE);
        pl_done();

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed loads from the preloaded window, ack tied high
        ack_mode = 0;
        run_txn(1'b0, 3'b000, 32'h100, 32'h0, 1'b1, 1'b0, d, e);
        check("lb_vec", d, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h100, 32'h0, 1'b1, 1'b0, d, e);
        check("lbu_vec", d, 32'h0000_0080);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1'b0, d, e);
        check("lh_vec", d, 32'hFFFF_FE12);
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1'b0, d, e);
        check("lw_vec", d, 32'hFE12_7F80);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 1'b0, d, e);

        // Misaligned halfword store with slow acks
        ack_mode = 1;
        run_txn(1'b1, 3'b001, 32'h201, 32'hAAAA_1234, 1'b0, 1'b0, d, e);
        check("sh_err", 32'(e), 32'(TRAP));

        // Illegal funct3 encodings
        ack_mode = 0;
        ill_st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ill_f3 = '{3'b011, 3'b110, 3'b111, 3'b011, 3'b100, 3'b111};
        for (int i = 0; i < 6; i++) begin
            run_txn(ill_st[i], ill_f3[i], 32'h104, 32'h5555_AAAA, 1'b1, 1'b0, d, e);
            check("illegal_err", 32'(e), 32'd1);
        end

        // Address wrap across the top of the address space
        run_txn(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, d, e);

        // Timeout with ack held low
        ack_mode = 2;
        run_txn(1'b0, 3'b010, 32'h104, 32'h0, 1'b1, 1'b1, d, e);
        check("tmo_data", d, 32'd0);

        // Reset in the middle of a word store
        ack_mode = 0;
        q0 = beat_addr_q.size();
        rp0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h380; req_wdata = 32'h1122_3344;
        check("rst_txn_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while ((beat_addr_q.size() - q0) < 2 && k < 20) begin @(posedge clk); #1; k++; end
        check("rst_txn_beats", 32'(beat_addr_q.size() - q0), 32'd2);
        ack_mode = 2;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_mem_req", 32'(mem_req), 32'd0);
        check("rst_abort_ready", 32'(req_ready), 32'd1);
        check("rst_abort_no_resp", 32'(resp_cnt - rp0), 32'd0);
        ref_mem[10'h380] = 8'h44;
        ref_mem[10'h381] = 8'h33;
        for (int i = 0; i < 4; i++)
            check("rst_abort_mem", 32'(mem[10'h380 + 10'(i)]), 32'(ref_mem[10'h380 + 10'(i)]));

        // Randomized mix of loads and stores
        for (int it = 0; it < 40; it++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] ad, wd;
            ack_mode = (it % 2 == 0) ? 0 : 3;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            ad = 32'h300 + 32'($urandom_range(0, 255));
            wd = $urandom;
            run_txn(st, f3, ad, wd, (ack_mode == 0), 1'b0, d, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
